// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer for the multi-cycle MIPS datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives every
// datapath enable/select and counts retired instructions.
// Optional build macro MEM_WAIT_EN: FETCH, MEMRD and MEMWR stall on
// mem_ready_i=0; without it mem_ready_i is ignored.
//
// state  | code | meaning
// FETCH  | 0    | read instruction, load IR, PC <= PC+4
// DECODE | 1    | branch target into ALUOut, dispatch on opcode
// MEMADR | 2    | effective address for lw/sw
// MEMRD  | 3    | data memory read
// MEMWB  | 4    | load result into register file
// MEMWR  | 5    | data memory write
// REXE   | 6    | R-type ALU operation
// ALUWB  | 7    | ALU result into register file
// BEQ    | 8    | compare and conditional PC load
// IEXE   | 9    | immediate ALU operation (addi/slti)
// JUMP   | 10   | PC <= jump target
// JAL    | 11   | PC <= jump target, $31 <= PC

module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             mem_ready_i,
  output logic             PCWrite_o,
  output logic             PCWriteCond_o,
  output logic             IorD_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             IRWrite_o,
  output logic             MemtoReg_o,
  output logic             RegDst_o,
  output logic             RegWrite_o,
  output logic             Jal_o,
  output logic             ALUSrcA_o,
  output logic [1:0]       ALUSrcB_o,
  output logic [2:0]       ALU_op_o,
  output logic [1:0]       PCSource_o,
  output logic [3:0]       state_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retire_cnt_o
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXE   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_IEXE   = 4'd9,
    S_JUMP   = 4'd10,
    S_JAL    = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       jal;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_JAL  = 6'd3;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_SLTI = 6'd10;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  state_t           state;
  state_t           state_nxt;
  ctrl_t            ctrl_q;
  logic             retire;
  logic             mem_ok;
  logic             fetch_gate;
  logic [CNT_W-1:0] retire_cnt;

`ifdef MEM_WAIT_EN
  assign mem_ok = mem_ready_i;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready_i;
  assign mem_ok           = 1'b1;
`endif

  // Control word for a state. The opcode only matters in IEXE (slti vs addi)
  // and ALUWB (rd vs rt); the IR holds it stable through both.
  function automatic ctrl_t decode(state_t s, logic [5:0] op);
    ctrl_t d;
    d = '0;
    case (s)
      S_FETCH: begin
        d.mem_read  = 1'b1;
        d.ir_write  = 1'b1;
        d.alu_src_b = 2'b01;
        d.alu_op    = 3'b010;
        d.pc_write  = 1'b1;
      end
      S_DECODE: begin
        d.alu_src_b = 2'b11;
        d.alu_op    = 3'b010;
      end
      S_MEMADR: begin
        d.alu_src_a = 1'b1;
        d.alu_src_b = 2'b10;
        d.alu_op    = 3'b010;
      end
      S_MEMRD: begin
        d.mem_read = 1'b1;
        d.iord     = 1'b1;
      end
      S_MEMWB: begin
        d.reg_write  = 1'b1;
        d.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        d.mem_write = 1'b1;
        d.iord      = 1'b1;
      end
      S_REXE: begin
        d.alu_src_a = 1'b1;
        d.alu_op    = 3'b000;
      end
      S_IEXE: begin
        d.alu_src_a = 1'b1;
        d.alu_src_b = 2'b10;
        d.alu_op    = (op == OP_SLTI) ? 3'b111 : 3'b010;
      end
      S_ALUWB: begin
        d.reg_write = 1'b1;
        d.reg_dst   = (op == OP_R);
      end
      S_BEQ: begin
        d.alu_src_a     = 1'b1;
        d.alu_op        = 3'b110;
        d.pc_write_cond = 1'b1;
        d.pc_source     = 2'b01;
      end
      S_JUMP: begin
        d.pc_write  = 1'b1;
        d.pc_source = 2'b10;
      end
      S_JAL: begin
        d.pc_write  = 1'b1;
        d.pc_source = 2'b10;
        d.reg_write = 1'b1;
        d.jal       = 1'b1;
      end
      default: d = '0;
    endcase
    return d;
  endfunction

  // Next-state and retire decision from the current state and opcode.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_FETCH:  if (mem_ok) state_nxt = S_DECODE;
      S_DECODE: begin
        case (instr_op_i)
          OP_LW, OP_SW:     state_nxt = S_MEMADR;
          OP_R:             state_nxt = S_REXE;
          OP_BEQ:           state_nxt = S_BEQ;
          OP_ADDI, OP_SLTI: state_nxt = S_IEXE;
          OP_J:             state_nxt = S_JUMP;
          OP_JAL:           state_nxt = S_JAL;
          default:          state_nxt = S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (instr_op_i == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ok) state_nxt = S_MEMWB;
      S_MEMWB: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ok) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_REXE, S_IEXE: state_nxt = S_ALUWB;
      S_ALUWB, S_BEQ, S_JUMP, S_JAL: begin
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
  end

  // State, registered control word and retire counter; reset wins over all.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= S_FETCH;
      ctrl_q     <= decode(S_FETCH, instr_op_i);
      retire_cnt <= '0;
    end else begin
      state  <= state_nxt;
      ctrl_q <= decode(state_nxt, instr_op_i);
      if (retire) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

  // IR/PC loads in FETCH wait for the memory; other states are unaffected.
  always_comb begin
    fetch_gate    = mem_ok | (state != S_FETCH);
    PCWrite_o     = ctrl_q.pc_write & fetch_gate;
    IRWrite_o     = ctrl_q.ir_write & fetch_gate;
    PCWriteCond_o = ctrl_q.pc_write_cond;
    IorD_o        = ctrl_q.iord;
    MemRead_o     = ctrl_q.mem_read;
    MemWrite_o    = ctrl_q.mem_write;
    MemtoReg_o    = ctrl_q.mem_to_reg;
    RegDst_o      = ctrl_q.reg_dst;
    RegWrite_o    = ctrl_q.reg_write;
    Jal_o         = ctrl_q.jal;
    ALUSrcA_o     = ctrl_q.alu_src_a;
    ALUSrcB_o     = ctrl_q.alu_src_b;
    ALU_op_o      = ctrl_q.alu_op;
    PCSource_o    = ctrl_q.pc_source;
    state_o       = state;
    retire_cnt_o  = retire_cnt;
    illegal_o     = 1'b0;
    if (state == S_DECODE) begin
      case (instr_op_i)
        OP_R, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_SLTI, OP_LW, OP_SW: illegal_o = 1'b0;
        default: illegal_o = 1'b1;
      endcase
    end
  end

endmodule
